// File: rtl/mmss_stopwatch_if.sv
// Control pulses and BCD display outputs of the mm:ss stopwatch.
// The master side drives the pulses and the slave side is the stopwatch core.
interface mmss_stopwatch_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] units_second;
  logic [3:0] tens_second;
  logic [3:0] units_minute;
  logic [3:0] tens_minute;
  logic       running;
  logic       wrap;
  logic       lap_active;

  modport master (
    output start_stop, clear, lap,
    input  units_second, tens_second, units_minute, tens_minute,
           running, wrap, lap_active
  );

  modport slave (
    input  start_stop, clear, lap,
    output units_second, tens_second, units_minute, tens_minute,
           running, wrap, lap_active
  );
endinterface

// File: rtl/mmss_stopwatch.sv
// mm:ss stopwatch: a prescaler derives the 1 Hz tick, and the count is held as four BCD digits
// that wrap at 59:59. Define LAP_HOLD_EN to add the lap freeze display register.
module mmss_stopwatch #(
  parameter  int TICKS_PER_SEC = 100000000,
  localparam int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
  input  logic             clk,
  input  logic             reset,
  mmss_stopwatch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_e;

  typedef struct packed {
    logic [3:0] tm;
    logic [3:0] um;
    logic [3:0] ts;
    logic [3:0] us;
  } mmss_t;

  state_e             state;
  logic [PRESC_W-1:0] presc;
  mmss_t              live;
  mmss_t              live_next;
  mmss_t              shown;
  logic               rollover;
  logic               tick;
  logic               running_q;
  logic               wrap_q;

  assign tick = (state == RUN) && (presc == PRESC_W'(TICKS_PER_SEC - 1));

  // NOTE: every output of an always_comb gets a default first, so that no path leaves it unassigned and infers a latch.
  always_comb begin
    live_next = live;
    rollover  = 1'b0;
    if (live.us != 4'd9) begin
      live_next.us = live.us + 4'd1;
    end else begin
      live_next.us = 4'd0;
      if (live.ts != 4'd5) begin
        live_next.ts = live.ts + 4'd1;
      end else begin
        live_next.ts = 4'd0;
        if (live.um != 4'd9) begin
          live_next.um = live.um + 4'd1;
        end else begin
          live_next.um = 4'd0;
          if (live.tm != 4'd5) begin
            live_next.tm = live.tm + 4'd1;
          end else begin
            live_next.tm = 4'd0;
            rollover     = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state     <= IDLE;
      presc     <= '0;
      live      <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state)
        IDLE: begin
          presc <= '0;
          if (bus.start_stop) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          // A tick and a start_stop pulse in the same cycle still take the increment.
          if (tick) begin
            presc  <= '0;
            live   <= live_next;
            wrap_q <= rollover;
          end else begin
            presc <= presc + 1'b1;
          end
          if (bus.start_stop) begin
            state     <= PAUSED;
            running_q <= 1'b0;
          end
        end
        PAUSED: begin
          if (bus.start_stop) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef LAP_HOLD_EN
  mmss_t disp;
  logic  lap_q;

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      lap_q <= 1'b0;
      disp  <= '0;
    end else if (bus.lap && (state == RUN) && !lap_q) begin
      lap_q <= 1'b1;
      disp  <= live;
    end else if (bus.lap && lap_q && (state != IDLE)) begin
      lap_q <= 1'b0;
    end
  end

  assign shown          = lap_q ? disp : live;
  assign bus.lap_active = lap_q;
`else
  logic unused_lap;
  assign unused_lap     = bus.lap;
  assign shown          = live;
  assign bus.lap_active = 1'b0;
`endif

  assign bus.units_second = shown.us;
  assign bus.tens_second  = shown.ts;
  assign bus.units_minute = shown.um;
  assign bus.tens_minute  = shown.tm;
  assign bus.running      = running_q;
  assign bus.wrap         = wrap_q;

endmodule

// File: tb/tb_mmss_stopwatch.sv
// Testbench for mmss_stopwatch with TICKS_PER_SEC=4. A reference model tracks elapsed seconds and the
// phase within the second, and it is compared against the DUT every cycle.
module tb_mmss_stopwatch;
  localparam int T = 4;

  logic clk;
  logic reset;
  mmss_stopwatch_if bus();

  mmss_stopwatch #(.TICKS_PER_SEC(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] digits;
  assign digits = {bus.tens_minute, bus.units_minute, bus.tens_second, bus.units_second};

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: 0 idle, 1 run, 2 paused; seconds elapsed 0..3599.
  int m_mode   = 0;
  int m_phase  = 0;
  int m_secs   = 0;
  int m_frozen = 0;
  bit m_wrap   = 1'b0;
  bit m_lap    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int s);
    int m;
    int c;
    m = s / 60;
    c = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_step(input bit rs, input bit ss, input bit cl, input bit lp);
    int old_secs;
    int old_mode;
    bit old_lap;
    old_secs = m_secs;
    old_mode = m_mode;
    old_lap  = m_lap;
    if (rs || cl) begin
      m_mode  = 0;
      m_phase = 0;
      m_secs  = 0;
      m_wrap  = 1'b0;
      m_lap   = 1'b0;
      return;
    end
    m_wrap = 1'b0;
    case (m_mode)
      0: begin
        m_phase = 0;
        if (ss) m_mode = 1;
      end
      1: begin
        if (m_phase == T - 1) begin
          m_phase = 0;
          m_secs  = (m_secs + 1) % 3600;
          m_wrap  = (m_secs == 0);
        end else begin
          m_phase++;
        end
        if (ss) m_mode = 2;
      end
      default: if (ss) m_mode = 1;
    endcase
`ifdef LAP_HOLD_EN
    if (lp && old_mode == 1 && !old_lap) begin
      m_lap    = 1'b1;
      m_frozen = old_secs;
    end else if (lp && old_lap && old_mode != 0) begin
      m_lap = 1'b0;
    end
`else
    if (lp) m_lap = 1'b0;
`endif
  endtask

  task automatic cycle(input bit rs, input bit ss, input bit cl, input bit lp);
    reset          = rs;
    bus.start_stop = ss;
    bus.clear      = cl;
    bus.lap        = lp;
    @(posedge clk);
    model_step(rs, ss, cl, lp);
    @(negedge clk);
    check("digits", digits, bcd(m_lap ? m_frozen : m_secs));
    check("running", bus.running, (m_mode == 1));
    check("wrap", bus.wrap, m_wrap);
    check("lap_active", bus.lap_active, m_lap);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wraps;
    int s0;
    reset          = 1'b1;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;

    repeat (3) cycle(1, 0, 0, 0);
    check("reset_digits", digits, 16'h0000);
    check("reset_running", bus.running, 1'b0);

    // Start, then 40 cycles gives ten seconds.
    cycle(0, 1, 0, 0);
    check("running_after_start", bus.running, 1'b1);
    repeat (40) cycle(0, 0, 0, 0);
    check("digits_00_10", digits, 16'h0010);

    // Run to 59:58, then across the rollover.
    n = 0;
    while (!(m_secs == 3598 && m_phase == 0) && n < 20000) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    check("reach_59_58", digits, 16'h5958);
    wraps = 0;
    repeat (8) begin
      cycle(0, 0, 0, 0);
      if (bus.wrap) begin
        wraps++;
        check("wrap_digits_zero", digits, 16'h0000);
      end
    end
    check("wrap_count", wraps, 1);
    check("after_wrap", digits, 16'h0000);

    // Pause with the prescaler held at 2, then resume.
    n = 0;
    while (m_phase != 1 && n < 10) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    cycle(0, 1, 0, 0);
    s0 = m_secs;
    repeat (50) begin
      cycle(0, 0, 0, 0);
      check("paused_hold", digits, bcd(s0));
    end
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check("resume_wait", digits, bcd(s0));
    cycle(0, 0, 0, 0);
    check("resume_tick", digits, bcd((s0 + 1) % 3600));

    // Assert clear and start_stop together at 03:27.
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    n = 0;
    while (m_secs != 207 && n < 2000) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    check("reach_03_27", digits, 16'h0327);
    cycle(0, 1, 1, 0);
    check("clear_ss_digits", digits, 16'h0000);
    check("clear_ss_running", bus.running, 1'b0);
    repeat (6) cycle(0, 0, 0, 0);
    check("idle_stays_zero", digits, 16'h0000);

    // A tick and start_stop in the same cycle at 00:05.
    cycle(0, 1, 0, 0);
    n = 0;
    while (!(m_secs == 5 && m_phase == T - 1) && n < 100) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    check("reach_00_05", digits, 16'h0005);
    cycle(0, 1, 0, 0);
    check("tick_ss_digits", digits, 16'h0006);
    check("tick_ss_running", bus.running, 1'b0);
    repeat (8) cycle(0, 0, 0, 0);
    check("paused_after_tick", digits, 16'h0006);

    // Lap freeze and release.
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    n = 0;
    while (!(m_secs == 3 && m_phase == 0) && n < 100) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    cycle(0, 0, 0, 1);
    repeat (12) cycle(0, 0, 0, 0);
`ifdef LAP_HOLD_EN
    check("lap_hold_digits", digits, 16'h0003);
    check("lap_hold_active", bus.lap_active, 1'b1);
    cycle(0, 0, 0, 1);
    check("lap_release_digits", digits, 16'h0006);
    check("lap_release_active", bus.lap_active, 1'b0);
`else
    check("lap_ignored_digits", digits, 16'h0006);
    check("lap_ignored_active", bus.lap_active, 1'b0);
    cycle(0, 0, 0, 1);
`endif

    // Random control pulses.
    repeat (3000) begin
      cycle(($urandom_range(0, 999) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
